// File: rtl/value_deliver_arbiter_if.sv
// rtl/value_deliver_arbiter_if.sv - requester/channel signal bundle for value_deliver_arbiter
interface value_deliver_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_value;
    logic [NUM_REQ-1:0]       gnt;
    logic                     pulse_out;
    logic [WIDTH-1:0]         value_out;
    logic                     busy;
    logic                     done_in;

    // Requester / destination side: raises requests and returns completion
    modport master (
        output req, req_value, done_in,
        input  gnt, pulse_out, value_out, busy
    );

    // Arbiter side: grants and launches onto the channel
    modport slave (
        input  req, req_value, done_in,
        output gnt, pulse_out, value_out, busy
    );
endinterface

// File: rtl/value_deliver_arbiter.sv
// rtl/value_deliver_arbiter.sv - round-robin launch arbiter with gap pacing (optional VALUE_ARB_ACK_WAIT_EN)
module value_deliver_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    value_deliver_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1
`ifdef VALUE_ARB_ACK_WAIT_EN
        ,ACK = 2'd2
`endif
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic               pulse_q;
    logic [WIDTH-1:0]   value_q;
    logic [PTR_W-1:0]   winner;
    logic               found;
    logic               can_launch;
    logic               launch;

`ifdef VALUE_ARB_ACK_WAIT_EN
    logic               ack_flag;
`else
    logic               unused_done;
    assign unused_done = bus.done_in;
`endif

    // Rotating priority search: first pending requester after the last winner
    always_comb begin
        int                idx;
        logic [PTR_W-1:0]  idx_w;
        found  = 1'b0;
        winner = ptr;
        idx    = 0;
        idx_w  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = PTR_W'(idx);
            if (!found && bus.req[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    // An ACK that completes this cycle frees the channel just like IDLE does
`ifdef VALUE_ARB_ACK_WAIT_EN
    assign can_launch = (state == IDLE) || ((state == ACK) && bus.done_in);
`else
    assign can_launch = (state == IDLE);
`endif
    assign launch = can_launch && found;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: launch into GAP, hold for the gap, optionally wait for the ack
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt == '0) begin
`ifdef VALUE_ARB_ACK_WAIT_EN
                    state_d = (ack_flag || bus.done_in) ? IDLE : ACK;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef VALUE_ARB_ACK_WAIT_EN
            ACK: begin
                if (bus.done_in) begin
                    state_d = launch ? GAP : IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Launch datapath: one-cycle grant/strobe, held value, pointer and gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            pulse_q <= 1'b0;
            value_q <= '0;
            ptr     <= PTR_W'(NUM_REQ - 1);
            cnt     <= '0;
        end else begin
            gnt_q   <= '0;
            pulse_q <= 1'b0;
            if (launch) begin
                gnt_q   <= NUM_REQ'(1) << winner;
                pulse_q <= 1'b1;
                value_q <= bus.req_value[int'(winner)*WIDTH +: WIDTH];
                ptr     <= winner;
                cnt     <= CNT_W'(GAP_CYCLES - 1);
            end else if ((state == GAP) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef VALUE_ARB_ACK_WAIT_EN
    // Remember a completion that arrives while the gap is still running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_flag <= 1'b0;
        end else if (launch) begin
            ack_flag <= 1'b0;
        end else if (((state == GAP) || (state == ACK)) && bus.done_in) begin
            ack_flag <= 1'b1;
        end
    end
`endif

    assign bus.gnt       = gnt_q;
    assign bus.pulse_out = pulse_q;
    assign bus.value_out = value_q;
    assign bus.busy      = (state != IDLE);
endmodule
